// File: rtl/dm_wb_cache_if.sv
`timescale 1ns/1ps
// Line-memory bus between the data cache (master) and the 128-bit line memory (slave).
// The master issues one-cycle cen pulses; the slave answers with stall/rdata.
interface dm_wb_cache_if #(
  parameter int BIT_W  = 32,
  parameter int ADDR_W = 32
);
  logic                 cen;
  logic                 wen;
  logic [ADDR_W-1:0]    addr;
  logic [BIT_W*4-1:0]   wdata;
  logic [BIT_W*4-1:0]   rdata;
  logic                 stall;

  modport master (
    output cen, wen, addr, wdata,
    input  rdata, stall
  );

  modport slave (
    input  cen, wen, addr, wdata,
    output rdata, stall
  );
endinterface

// File: rtl/dm_wb_cache.sv
`timescale 1ns/1ps
// Direct-mapped, write-back, write-allocate data cache.
// CPU hits are served from the line array with no memory traffic; misses write back a dirty
// victim (if any) and then fill the line, after which the held CPU request hits.
// An end-of-program flush writes every dirty line back in ascending index order.
module dm_wb_cache #(
  parameter int BIT_W     = 32,
  parameter int ADDR_W    = 32,
  parameter int NUM_LINES = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_proc_cen,
  input  logic                i_proc_wen,
  input  logic [ADDR_W-1:0]   i_proc_addr,
  input  logic [BIT_W-1:0]    i_proc_wdata,
  output logic [BIT_W-1:0]    o_proc_rdata,
  output logic                o_proc_stall,
  input  logic                i_proc_finish,
  output logic                o_cache_finish,
  dm_wb_cache_if.master       mem
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int TAG_W  = ADDR_W - 4 - IDX_W;
  localparam int LINE_W = BIT_W * 4;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WB    = 3'd1,
    S_ALLOC = 3'd2,
    S_FLUSH = 3'd3,
    S_FWB   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  // Line storage
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [TAG_W-1:0]     tag_r  [NUM_LINES];
  logic [LINE_W-1:0]    data_r [NUM_LINES];

  // FSM and memory-bus registers
  state_t               state_r, state_nxt_s;
  logic                 mem_cen_r, mem_cen_nxt_s;
  logic                 mem_wen_r, mem_wen_nxt_s;
  logic [ADDR_W-1:0]    mem_addr_r, mem_addr_nxt_s;
  logic [LINE_W-1:0]    mem_wdata_r, mem_wdata_nxt_s;
  logic [IDX_W-1:0]     flush_idx_r, flush_idx_nxt_s;
  logic                 finish_r, finish_nxt_s;

  // Request decode and control strobes
  logic [IDX_W-1:0]     req_idx_s;
  logic [TAG_W-1:0]     req_tag_s;
  logic [1:0]           word_s;
  logic [LINE_W-1:0]    line_s;
  logic [BIT_W-1:0]     rd_word_s;
  logic                 hit_s;
  logic                 resp_s;
  logic                 wr_hit_s;
  logic                 fill_s;
  logic                 clr_dirty_s;
  logic [IDX_W-1:0]     clr_idx_s;
  logic                 unused_s;

  assign req_idx_s = i_proc_addr[4 +: IDX_W];
  assign req_tag_s = i_proc_addr[4 + IDX_W +: TAG_W];
  assign word_s    = i_proc_addr[3:2];
  assign unused_s  = ^i_proc_addr[1:0];
  assign line_s    = data_r[req_idx_s];
  assign rd_word_s = line_s[word_s * BIT_W +: BIT_W];
  assign hit_s     = valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
  // The issue cycle is the one with cen high; any later cycle without stall is the response.
  assign resp_s    = ~mem_cen_r & ~mem.stall;

  assign o_proc_stall   = (i_proc_cen & ~hit_s) | (state_r != S_IDLE);
  assign o_proc_rdata   = (i_proc_cen & ~i_proc_wen & ~o_proc_stall) ? rd_word_s : {BIT_W{1'b0}};
  assign o_cache_finish = finish_r;
  assign mem.cen        = mem_cen_r;
  assign mem.wen        = mem_wen_r;
  assign mem.addr       = mem_addr_r;
  assign mem.wdata      = mem_wdata_r;

  // Next-state logic; memory outputs only change when a new transaction is issued
  always_comb begin
    state_nxt_s     = state_r;
    mem_cen_nxt_s   = 1'b0;
    mem_wen_nxt_s   = mem_wen_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    flush_idx_nxt_s = flush_idx_r;
    finish_nxt_s    = finish_r;
    wr_hit_s        = 1'b0;
    fill_s          = 1'b0;
    clr_dirty_s     = 1'b0;
    clr_idx_s       = req_idx_s;
    case (state_r)
      S_IDLE: begin
        if (i_proc_cen) begin
          if (hit_s) begin
            wr_hit_s = i_proc_wen;
          end else if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
            state_nxt_s     = S_WB;
            mem_cen_nxt_s   = 1'b1;
            mem_wen_nxt_s   = 1'b1;
            mem_addr_nxt_s  = {tag_r[req_idx_s], req_idx_s, 4'b0000};
            mem_wdata_nxt_s = line_s;
          end else begin
            state_nxt_s    = S_ALLOC;
            mem_cen_nxt_s  = 1'b1;
            mem_wen_nxt_s  = 1'b0;
            mem_addr_nxt_s = {req_tag_s, req_idx_s, 4'b0000};
          end
        end else if (i_proc_finish && !finish_r) begin
          state_nxt_s     = S_FLUSH;
          flush_idx_nxt_s = {IDX_W{1'b0}};
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WB: begin
        if (resp_s) begin
          clr_dirty_s    = 1'b1;
          state_nxt_s    = S_ALLOC;
          mem_cen_nxt_s  = 1'b1;
          mem_wen_nxt_s  = 1'b0;
          mem_addr_nxt_s = {req_tag_s, req_idx_s, 4'b0000};
        end else begin
          state_nxt_s = S_WB;
        end
      end
      S_ALLOC: begin
        if (resp_s) begin
          fill_s      = 1'b1;
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_ALLOC;
        end
      end
      S_FLUSH: begin
        if (valid_r[flush_idx_r] && dirty_r[flush_idx_r]) begin
          state_nxt_s     = S_FWB;
          mem_cen_nxt_s   = 1'b1;
          mem_wen_nxt_s   = 1'b1;
          mem_addr_nxt_s  = {tag_r[flush_idx_r], flush_idx_r, 4'b0000};
          mem_wdata_nxt_s = data_r[flush_idx_r];
        end else if (flush_idx_r == LAST_IDX) begin
          state_nxt_s  = S_DONE;
          finish_nxt_s = 1'b1;
        end else begin
          flush_idx_nxt_s = flush_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end
      S_FWB: begin
        if (resp_s) begin
          clr_dirty_s = 1'b1;
          clr_idx_s   = flush_idx_r;
          if (flush_idx_r == LAST_IDX) begin
            state_nxt_s  = S_DONE;
            finish_nxt_s = 1'b1;
          end else begin
            state_nxt_s     = S_FLUSH;
            flush_idx_nxt_s = flush_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
          end
        end else begin
          state_nxt_s = S_FWB;
        end
      end
      S_DONE: begin
        state_nxt_s = S_DONE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // FSM state, flush scan index, finish flag and memory-bus output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= S_IDLE;
      mem_cen_r   <= 1'b0;
      mem_wen_r   <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {LINE_W{1'b0}};
      flush_idx_r <= {IDX_W{1'b0}};
      finish_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      mem_cen_r   <= mem_cen_nxt_s;
      mem_wen_r   <= mem_wen_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      flush_idx_r <= flush_idx_nxt_s;
      finish_r    <= finish_nxt_s;
    end
  end

  // Per-line valid and dirty bits
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_r <= {NUM_LINES{1'b0}};
      dirty_r <= {NUM_LINES{1'b0}};
    end else if (fill_s) begin
      valid_r[req_idx_s] <= 1'b1;
      dirty_r[req_idx_s] <= 1'b0;
    end else if (wr_hit_s) begin
      dirty_r[req_idx_s] <= 1'b1;
    end else if (clr_dirty_s) begin
      dirty_r[clr_idx_s] <= 1'b0;
    end
  end

  // Tag and data arrays; contents are meaningless until valid is set, so no reset
  always_ff @(posedge i_clk) begin
    if (fill_s) begin
      data_r[req_idx_s] <= mem.rdata;
      tag_r[req_idx_s]  <= req_tag_s;
    end else if (wr_hit_s) begin
      data_r[req_idx_s][word_s * BIT_W +: BIT_W] <= i_proc_wdata;
    end
  end
endmodule

// File: tb/tb_dm_wb_cache.sv
`timescale 1ns/1ps
// Self-checking bench for dm_wb_cache: directed line-memory scenarios, a table of hit vectors,
// and random traffic checked against a flat word-memory reference with a direct-mapped hit model.
module tb_dm_wb_cache;
  logic        clk, rst, cen, wen, finish, stall, cache_finish;
  logic [31:0] addr, wdata, rdata;
  int          total = 0;
  int          bad = 0;

  dm_wb_cache_if #(.BIT_W(32), .ADDR_W(32)) mem_if ();

  dm_wb_cache dut (
    .i_clk(clk), .i_rst(rst), .i_proc_cen(cen), .i_proc_wen(wen), .i_proc_addr(addr),
    .i_proc_wdata(wdata), .o_proc_rdata(rdata), .o_proc_stall(stall),
    .i_proc_finish(finish), .o_cache_finish(cache_finish), .mem(mem_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic         wen;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } txn_t;

  typedef struct {
    logic        cen;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;

  logic [127:0] store [int unsigned];
  txn_t         txq[$];
  int           stall_len = 0;
  int           cen_cycles = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] defw(input logic [31:0] a);
    return ~{a[31:2], 2'b00};
  endfunction

  function automatic logic [127:0] get_line(input logic [31:0] la);
    if (store.exists(la)) return store[la];
    return {defw(la + 32'd12), defw(la + 32'd8), defw(la + 32'd4), defw(la)};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [127:0] l;
    l = get_line({a[31:4], 4'b0000});
    return l[a[3:2] * 32 +: 32];
  endfunction

  // Line memory: latches a transaction at issue, stalls stall_len cycles, then responds
  initial begin : memory_model
    txn_t rec;
    bit   pend;
    int   remaining;
    pend = 1'b0;
    remaining = 0;
    mem_if.stall = 1'b0;
    mem_if.rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
        mem_if.stall = 1'b0;
      end else if (mem_if.cen) begin
        cen_cycles++;
        chk("mem cen while busy", {127'd0, pend}, 128'd0);
        rec = '{wen: mem_if.wen, addr: mem_if.addr, wdata: mem_if.wdata};
        txq.push_back(rec);
        pend = 1'b1;
        remaining = stall_len;
        mem_if.stall = 1'b1;
      end else if (pend) begin
        chk("mem hold addr", {96'd0, mem_if.addr}, {96'd0, rec.addr});
        chk("mem hold wen", {127'd0, mem_if.wen}, {127'd0, rec.wen});
        chk("mem hold wdata", mem_if.wdata, rec.wdata);
        if (remaining > 0) begin
          remaining--;
          mem_if.stall = 1'b1;
        end else begin
          mem_if.stall = 1'b0;
          if (rec.wen) begin
            store[rec.addr] = rec.wdata;
            mem_if.rdata = '0;
          end else begin
            mem_if.rdata = get_line(rec.addr);
          end
          pend = 1'b0;
        end
      end else begin
        mem_if.stall = 1'b0;
      end
    end
  end

  // All driver tasks start and end 1ns after a rising edge
  task automatic do_reset();
    rst = 1'b1; cen = 1'b0; wen = 1'b0; finish = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic cpu_op(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int nstall);
    cen = 1'b1; wen = w; addr = a; wdata = d; nstall = 0;
    @(negedge clk);
    while (stall && nstall < 500) begin
      nstall++;
      @(negedge clk);
    end
    chk("op completes", {127'd0, stall}, 128'd0);
    rd = rdata;
    @(posedge clk);
    #1 cen = 1'b0;
  endtask

  task automatic wait_finish();
    for (int i = 0; i < 400 && !cache_finish; i++) @(negedge clk);
    chk("flush completes", {127'd0, cache_finish}, 128'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    vec_t         vt[8];
    logic [31:0]  rd;
    int           ns;
    logic [31:0]  ref_w [int unsigned];
    logic [31:0]  m_line [4];
    bit           m_valid [4];
    bit           m_dirty [4];

    vt[0] = '{1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b0, 32'hFFFE_FFFF};
    vt[1] = '{1'b1, 1'b0, 32'h0001_0004, 32'h0, 1'b0, 32'hDEAD_BEEF};
    vt[2] = '{1'b1, 1'b0, 32'h0001_0008, 32'h0, 1'b0, 32'h1234_5678};
    vt[3] = '{1'b1, 1'b1, 32'h0001_000C, 32'hCAFE_F00D, 1'b0, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h0001_000F, 32'h0, 1'b0, 32'hCAFE_F00D};
    vt[5] = '{1'b0, 1'b0, 32'h0001_0004, 32'h0, 1'b0, 32'h0};
    vt[6] = '{1'b1, 1'b1, 32'h0001_0000, 32'h0, 1'b0, 32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h0001_0001, 32'h0, 1'b0, 32'h0};

    addr = '0; wdata = '0;
    store[32'h0001_0000] = {defw(32'h0001_000C), defw(32'h0001_0008), 32'hDEAD_BEEF, defw(32'h0001_0000)};
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst finish", {127'd0, cache_finish}, 128'd0);
    chk("rst mem cen", {127'd0, mem_if.cen}, 128'd0);
    chk("rst mem wen", {127'd0, mem_if.wen}, 128'd0);
    chk("rst mem addr", {96'd0, mem_if.addr}, 128'd0);
    chk("rst mem wdata", mem_if.wdata, 128'd0);
    chk("rst stall", {127'd0, stall}, 128'd0);
    chk("rst rdata", {96'd0, rdata}, 128'd0);
    @(posedge clk); #1;

    // 1) read miss, then repeat read hits
    txq.delete();
    cpu_op(1'b0, 32'h0001_0004, 32'h0, rd, ns);
    chk("t1 rdata", {96'd0, rd}, {96'd0, 32'hDEAD_BEEF});
    chk("t1 stalls", ns, 3);
    chk("t1 txn count", txq.size(), 1);
    chk("t1 txn addr", {96'd0, txq[0].addr}, {96'd0, 32'h0001_0000});
    chk("t1 txn wen", {127'd0, txq[0].wen}, 128'd0);
    cpu_op(1'b0, 32'h0001_0004, 32'h0, rd, ns);
    chk("t1 hit rdata", {96'd0, rd}, {96'd0, 32'hDEAD_BEEF});
    chk("t1 hit stalls", ns, 0);

    // 2) write hit, then table of hit vectors on the same line
    cpu_op(1'b1, 32'h0001_0008, 32'h1234_5678, rd, ns);
    chk("t2 write stalls", ns, 0);
    for (int i = 0; i < 8; i++) begin
      cen = vt[i].cen; wen = vt[i].wen; addr = vt[i].addr; wdata = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d stall", i), {127'd0, stall}, {127'd0, vt[i].exp_stall});
      chk($sformatf("vec%0d rdata", i), {96'd0, rdata}, {96'd0, vt[i].exp_rdata});
      @(posedge clk); #1;
    end
    cen = 1'b0;
    chk("t2 no mem traffic", txq.size(), 1);

    // 3) conflicting read at index 0: write-back then fill
    txq.delete();
    cpu_op(1'b0, 32'h0001_0108, 32'h0, rd, ns);
    chk("t3 rdata", {96'd0, rd}, {96'd0, defw(32'h0001_0108)});
    chk("t3 stalls", ns, 5);
    chk("t3 txn count", txq.size(), 2);
    chk("t3 wb wen", {127'd0, txq[0].wen}, 128'd1);
    chk("t3 wb addr", {96'd0, txq[0].addr}, {96'd0, 32'h0001_0000});
    chk("t3 wb data", txq[0].wdata, {32'hCAFE_F00D, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0});
    chk("t3 fill wen", {127'd0, txq[1].wen}, 128'd0);
    chk("t3 fill addr", {96'd0, txq[1].addr}, {96'd0, 32'h0001_0100});

    // 4) dirty lines at idx 0 and 5, then flush
    cpu_op(1'b1, 32'h0001_0100, 32'h1111_1111, rd, ns);
    chk("t4 idx0 write stalls", ns, 0);
    cpu_op(1'b1, 32'h0001_0050, 32'h5555_5555, rd, ns);
    chk("t4 idx5 write stalls", ns, 3);
    txq.delete();
    finish = 1'b1;
    wait_finish();
    finish = 1'b0;
    chk("t4 flush count", txq.size(), 2);
    chk("t4 flush0 addr", {96'd0, txq[0].addr}, {96'd0, 32'h0001_0100});
    chk("t4 flush0 data", txq[0].wdata,
        {defw(32'h0001_010C), defw(32'h0001_0108), defw(32'h0001_0104), 32'h1111_1111});
    chk("t4 flush1 addr", {96'd0, txq[1].addr}, {96'd0, 32'h0001_0050});
    chk("t4 mem word5", {96'd0, mem_word(32'h0001_0050)}, {96'd0, 32'h5555_5555});
    cen = 1'b1; wen = 1'b0; addr = 32'h0001_0100;
    repeat (5) @(negedge clk);
    chk("t4 finish held", {127'd0, cache_finish}, 128'd1);
    chk("t4 done stalls cpu", {127'd0, stall}, 128'd1);
    chk("t4 done rdata", {96'd0, rdata}, 128'd0);
    @(posedge clk); #1 cen = 1'b0;

    // 6) memory stall held 10 cycles
    do_reset();
    stall_len = 10; cen_cycles = 0; txq.delete();
    cpu_op(1'b0, 32'h0001_0004, 32'h0, rd, ns);
    chk("t6 rdata", {96'd0, rd}, {96'd0, 32'hDEAD_BEEF});
    chk("t6 stalls", ns, 13);
    chk("t6 cen cycles", cen_cycles, 1);

    // 5) reset during the fill wait
    stall_len = 20; txq.delete();
    cen = 1'b1; wen = 1'b0; addr = 32'h0001_0200;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_if.cen) break;
    end
    chk("t5 fill issued", {127'd0, mem_if.cen}, 128'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1; cen = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("t5 mem cen", {127'd0, mem_if.cen}, 128'd0);
    chk("t5 stall", {127'd0, stall}, 128'd0);
    @(posedge clk); #1;
    stall_len = 0; txq.delete();
    cpu_op(1'b0, 32'h0001_0004, 32'h0, rd, ns);
    chk("t5 re-miss stalls", ns, 3);
    chk("t5 re-miss txns", txq.size(), 1);
    chk("t5 rdata", {96'd0, rd}, {96'd0, 32'hDEAD_BEEF});

    // Random traffic against a flat-memory reference and a direct-mapped residency model
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_line[i] = '0;
    end
    for (int n = 0; n < 120; n++) begin
      int          t, ix, w, lat, exp_st;
      logic        we;
      logic [31:0] a, la, d;
      bit          hit;
      t = $urandom_range(0, 2); ix = $urandom_range(0, 3); w = $urandom_range(0, 3);
      we = 1'($urandom_range(0, 1)); d = $urandom; lat = $urandom_range(0, 3);
      a = 32'h0002_0000 + 32'(t * 256 + ix * 16 + w * 4);
      la = {a[31:4], 4'b0000};
      hit = m_valid[ix] && (m_line[ix] == la);
      exp_st = hit ? 0 : ((m_valid[ix] && m_dirty[ix]) ? 2 * lat + 5 : lat + 3);
      stall_len = lat;
      cpu_op(we, a, d, rd, ns);
      chk($sformatf("rnd%0d stalls", n), ns, exp_st);
      if (we) begin
        ref_w[a] = d;
      end else begin
        chk($sformatf("rnd%0d rdata", n), {96'd0, rd},
            {96'd0, ref_w.exists(a) ? ref_w[a] : defw(a)});
      end
      if (!hit) m_dirty[ix] = 1'b0;
      if (we) m_dirty[ix] = 1'b1;
      m_valid[ix] = 1'b1;
      m_line[ix] = la;
    end
    begin
      int ndirty;
      ndirty = 0;
      for (int i = 0; i < 4; i++) if (m_valid[i] && m_dirty[i]) ndirty++;
      txq.delete();
      finish = 1'b1;
      wait_finish();
      finish = 1'b0;
      chk("rnd flush count", txq.size(), ndirty);
      foreach (ref_w[k]) chk($sformatf("rnd mem %0h", k), {96'd0, mem_word(k)}, {96'd0, ref_w[k]});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
